rc4_byte_serializer: RTL and testbench
======================================

RC4_BYTE_SERIALIZER -- requirements
Module: rc4_byte_serializer

Interface
REQ-001 Parameter: DEPTH, 4, ciphertext word FIFO depth; power of two, 2..16.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: ctxt_in  input  32  ciphertext word from the RC4 stage; byte0 = [7:0] ... byte3 = [31:24].
REQ-005 Port: ctxt_valid  input  1  ctxt_in holds a word to accept.
REQ-006 Port: ctxt_ready  output  1  block can accept a word this cycle.
REQ-007 Port: out_byte  output  8  serialized ciphertext byte.
REQ-008 Port: out_valid  output  1  out_byte is valid.
REQ-009 Port: out_ready  input  1  downstream consumes out_byte this cycle.
REQ-010 Port: fifo_count  output  clog2(DEPTH)+1  number of words stored in the FIFO, excluding the word in the shift register.

Function
REQ-011 A word SHALL be accepted on a rising edge where ctxt_valid and ctxt_ready are both 1.
REQ-012 ctxt_ready SHALL equal (fifo_count != DEPTH); a pop in the same cycle SHALL NOT free a slot for that cycle.
REQ-013 The FIFO SHALL be circular; read and write pointers wrap from DEPTH-1 to 0.
REQ-014 The FSM SHALL have two states: IDLE (shift register empty) and SEND (shift register holds a word, byte index 0..3).
REQ-015 In IDLE with fifo_count>0, the FSM SHALL pop the head word into the shift register, set the index to 0 and move to SEND on the same edge.
REQ-016 In SEND, out_valid SHALL be 1 and out_byte SHALL be the shift register's [7:0]; in IDLE, out_valid SHALL be 0 and out_byte SHALL be 8'h00.
REQ-017 On an out_valid&&out_ready edge with index<3, the shift register SHALL shift right by 8 and the index SHALL increment.
REQ-018 On an out_valid&&out_ready edge with index==3, the FSM SHALL pop the next word and stay in SEND with index 0 if fifo_count>0; otherwise it SHALL return to IDLE.
REQ-019 Bytes SHALL leave in order byte0, byte1, byte2, byte3, word by word in arrival order; no byte SHALL be dropped or repeated.
REQ-020 When the FIFO is empty, a word accepted at edge E SHALL produce out_valid=1 after edge E+1, giving a 2-cycle minimum latency.
REQ-021 A push and a pop on the same edge SHALL leave fifo_count unchanged.
REQ-022 While out_ready=0, out_byte and out_valid SHALL be held stable.
REQ-023 Throughput SHALL be one byte per clock while out_ready=1 and the FIFO is non-empty, with no bubble between words.

Reset
REQ-024 While rst=1 at an edge, the block SHALL clear both pointers, set fifo_count=0, enter IDLE, and drive out_valid=0, out_byte=8'h00 and ctxt_ready=1 after that edge.
REQ-025 Reset asserted mid-word SHALL discard the partially sent word and all FIFO contents; ctxt_valid SHALL be ignored during reset.
REQ-026 FIFO storage SHALL NOT need a reset value.

Configuration
REQ-027 With macro RC4SER_PARITY_EN defined, the block SHALL add output port out_parity (1 bit) = even-parity XOR of out_byte, valid with out_valid and 0 in IDLE and on reset.
REQ-028 Without RC4SER_PARITY_EN, out_parity SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-029 After reset, push 32'hA1B2C3D4 with out_ready=1 -> out_valid rises 2 cycles later; bytes D4,C3,B2,A1 appear on consecutive cycles, then out_valid=0.
REQ-030 With out_ready=0, push 5 words at DEPTH=4 -> fifo_count reaches 3 while the shift register holds word 1 and 4 once word 5 is accepted; ctxt_ready=0; a 6th word is refused.
REQ-031 Back-to-back words 32'h03020100 and 32'h07060504 with out_ready=1 -> bytes 00..07 on 8 consecutive cycles with no gap.
REQ-032 Toggle out_ready every cycle during one word -> each byte is held until consumed; the sequence is unchanged.
REQ-033 Assert rst after byte1 of a word while 2 words are queued -> the next cycle shows out_valid=0 and fifo_count=0; a new word pushed afterwards is emitted from byte0.
REQ-034 (RC4SER_PARITY_EN) Push 32'h000000FF then 32'h00000001 -> out_parity=0 for byte FF and 1 for byte 01.

Source files
------------

// File: rtl/rc4_byte_serializer.sv
// rc4_byte_serializer
//   Buffers 32-bit RC4 ciphertext words in a small circular FIFO and emits
//   them one byte per handshake, least-significant byte first
//   (byte0 = [7:0] ... byte3 = [31:24]).
//
// Parameters
//   DEPTH       ciphertext word FIFO depth (power of two, 2..16)
//
// Ports
//   clk         single clock, rising-edge
//   rst         synchronous active-high reset
//   ctxt_in     ciphertext word from the RC4 stage
//   ctxt_valid  ctxt_in holds a word to accept
//   ctxt_ready  a word can be accepted this cycle (FIFO not full)
//   out_byte    serialized ciphertext byte (8'h00 when idle)
//   out_valid   out_byte is valid
//   out_ready   downstream consumes out_byte this cycle
//   fifo_count  words held in the FIFO, not counting the word being sent
//   out_parity  XOR of out_byte bits; only present when the build
//               defines macro RC4SER_PARITY_EN
module rc4_byte_serializer #(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               ctxt_in,
  input  logic                      ctxt_valid,
  output logic                      ctxt_ready,
  output logic [7:0]                out_byte,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    fifo_count
`ifdef RC4SER_PARITY_EN
  ,
  output logic                      out_parity
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Word storage; no reset needed because the pointers and count define
  // which entries are meaningful.
  logic [31:0]   mem_q [DEPTH];

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   sr_q, sr_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    out_byte_q, out_byte_d;
  logic          out_valid_q, out_valid_d;
`ifdef RC4SER_PARITY_EN
  logic          out_parity_q, out_parity_d;
`endif

  logic          push;
  logic          pop;

  // Readiness depends only on the registered count, so a pop on the same
  // edge does not make room for a push in that cycle.
  assign ctxt_ready = (count_q != CW'(DEPTH));
  assign fifo_count = count_q;
  assign out_byte   = out_byte_q;
  assign out_valid  = out_valid_q;
`ifdef RC4SER_PARITY_EN
  assign out_parity = out_parity_q;
`endif

  always_comb begin
    push     = ctxt_valid && ctxt_ready;
    pop      = 1'b0;
    state_d  = state_q;
    sr_d     = sr_q;
    idx_d    = idx_q;

    if (state_q == IDLE) begin
      if (count_q != '0) begin
        pop     = 1'b1;
        sr_d    = mem_q[rd_ptr_q];
        idx_d   = 2'd0;
        state_d = SEND;
      end
    end else begin
      if (out_ready) begin
        if (idx_q != 2'd3) begin
          sr_d  = {8'h00, sr_q[31:8]};
          idx_d = idx_q + 2'd1;
        end else if (count_q != '0) begin
          // Reload straight from the FIFO so words run back to back.
          pop   = 1'b1;
          sr_d  = mem_q[rd_ptr_q];
          idx_d = 2'd0;
        end else begin
          state_d = IDLE;
        end
      end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    wr_ptr_d = push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);

    // Outputs are registered from the next-state values so they line up
    // with the state they describe.
    out_valid_d = (state_d == SEND);
    out_byte_d  = out_valid_d ? sr_d[7:0] : 8'h00;
`ifdef RC4SER_PARITY_EN
    out_parity_d = out_valid_d ? (^sr_d[7:0]) : 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= ctxt_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      idx_q        <= 2'd0;
      out_byte_q   <= 8'h00;
      out_valid_q  <= 1'b0;
`ifdef RC4SER_PARITY_EN
      out_parity_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      out_byte_q   <= out_byte_d;
      out_valid_q  <= out_valid_d;
`ifdef RC4SER_PARITY_EN
      out_parity_q <= out_parity_d;
`endif
    end
    // Shift register is datapath only; its contents are ignored in IDLE.
    sr_q <= sr_d;
  end

endmodule

// File: tb/tb_rc4_byte_serializer.sv
module tb_rc4_byte_serializer;

  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [31:0]            ctxt_in;
  logic                   ctxt_valid;
  logic                   ctxt_ready;
  logic [7:0]             out_byte;
  logic                   out_valid;
  logic                   out_ready;
  logic [$clog2(DEPTH):0] fifo_count;
`ifdef RC4SER_PARITY_EN
  logic                   out_parity;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rc4_byte_serializer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .ctxt_in    (ctxt_in),
    .ctxt_valid (ctxt_valid),
    .ctxt_ready (ctxt_ready),
    .out_byte   (out_byte),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_count (fifo_count)
`ifdef RC4SER_PARITY_EN
    ,
    .out_parity (out_parity)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    ctxt_valid = 1'b0;
    ctxt_in    = 32'h0;
    out_ready  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    ctxt_valid = 1'b1;
    ctxt_in    = $urandom;
    out_ready  = 1'b1;
    tick();
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++;
    if (out_byte !== 8'h00) begin n_fail++; $display("FAIL reset_byte: got %h want 00", out_byte); end
    n_checks++;
    if (fifo_count !== 0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    n_checks++;
    if (ctxt_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ctxt_ready); end
`ifdef RC4SER_PARITY_EN
    n_checks++;
    if (out_parity !== 1'b0) begin n_fail++; $display("FAIL reset_parity: got %b want 0", out_parity); end
`endif
    rst        = 1'b0;
    ctxt_valid = 1'b0;
  endtask

  task automatic test_single_word();
    logic [31:0] w;
    w = 32'hA1B2C3D4;
    do_reset();
    out_ready  = 1'b1;
    ctxt_valid = 1'b1;
    ctxt_in    = w;
    tick();
    ctxt_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency1: valid got %b want 0", out_valid); end
    tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_byte !== w[8*i +: 8]) begin
        n_fail++;
        $display("FAIL single_byte%0d: got v=%b %h want v=1 %h", i, out_valid, out_byte, w[8*i +: 8]);
      end
      tick();
    end
    n_checks++;
    if (out_valid !== 1'b0 || out_byte !== 8'h00) begin
      n_fail++; $display("FAIL single_end: got v=%b %h want v=0 00", out_valid, out_byte);
    end
  endtask

  task automatic test_full();
    logic [31:0] w [5];
    logic [31:0] cur;
    for (int i = 0; i < 5; i++) w[i] = $urandom;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ctxt_valid = 1'b1;
      ctxt_in    = w[i];
      tick();
      if (i == 3) begin
        n_checks++;
        if (fifo_count !== 3 || out_valid !== 1'b1 || out_byte !== w[0][7:0]) begin
          n_fail++;
          $display("FAIL full_count3: got cnt=%0d v=%b %h want cnt=3 v=1 %h", fifo_count, out_valid, out_byte, w[0][7:0]);
        end
      end
    end
    n_checks++;
    if (fifo_count !== 4 || ctxt_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_count4: got cnt=%0d rdy=%b want cnt=4 rdy=0", fifo_count, ctxt_ready);
    end
    ctxt_in = $urandom;
    tick();
    ctxt_valid = 1'b0;
    n_checks++;
    if (fifo_count !== 4) begin n_fail++; $display("FAIL full_refuse: got cnt=%0d want 4", fifo_count); end
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cur = w[k/4];
      n_checks++;
      if (out_valid !== 1'b1 || out_byte !== cur[8*(k%4) +: 8]) begin
        n_fail++;
        $display("FAIL full_drain%0d: got v=%b %h want v=1 %h", k, out_valid, out_byte, cur[8*(k%4) +: 8]);
      end
      tick();
    end
    n_checks++;
    if (out_valid !== 1'b0 || fifo_count !== 0) begin
      n_fail++; $display("FAIL full_empty: got v=%b cnt=%0d want v=0 cnt=0", out_valid, fifo_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready  = 1'b1;
    ctxt_valid = 1'b1;
    ctxt_in    = 32'h03020100;
    tick();
    ctxt_in    = 32'h07060504;
    tick();
    ctxt_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_byte !== 8'(i)) begin
        n_fail++; $display("FAIL b2b_byte%0d: got v=%b %h want v=1 %h", i, out_valid, out_byte, 8'(i));
      end
      tick();
    end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got v=%b want 0", out_valid); end
  endtask

  task automatic test_toggle_ready();
    logic [31:0] w;
    logic [7:0]  held;
    logic        held_v;
    int          got;
    w = $urandom;
    do_reset();
    ctxt_valid = 1'b1;
    ctxt_in    = w;
    tick();
    ctxt_valid = 1'b0;
    held_v = 1'b0;
    held   = 8'h00;
    got    = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      out_ready = cyc[0];
      if (held_v) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_byte !== held) begin
          n_fail++; $display("FAIL toggle_hold: got v=%b %h want v=1 %h", out_valid, out_byte, held);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (out_byte !== w[8*got +: 8]) begin
          n_fail++; $display("FAIL toggle_byte%0d: got %h want %h", got, out_byte, w[8*got +: 8]);
        end
        got++;
      end
      held_v = out_valid && !out_ready;
      held   = out_byte;
      tick();
    end
    n_checks++;
    if (got != 4) begin n_fail++; $display("FAIL toggle_timeout: got %0d bytes want 4", got); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_word();
    logic [31:0] nw;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ctxt_valid = 1'b1;
      ctxt_in    = $urandom;
      tick();
    end
    ctxt_valid = 1'b0;
    n_checks++;
    if (fifo_count !== 2) begin n_fail++; $display("FAIL rstmid_queued: got cnt=%0d want 2", fifo_count); end
    out_ready = 1'b1;
    tick();
    tick();
    rst        = 1'b1;
    ctxt_valid = 1'b1;
    ctxt_in    = $urandom;
    tick();
    rst        = 1'b0;
    ctxt_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || fifo_count !== 0 || out_byte !== 8'h00 || ctxt_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_clear: got v=%b cnt=%0d b=%h rdy=%b want v=0 cnt=0 b=00 rdy=1", out_valid, fifo_count, out_byte, ctxt_ready);
    end
    nw = $urandom;
    ctxt_valid = 1'b1;
    ctxt_in    = nw;
    tick();
    ctxt_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_byte !== nw[8*i +: 8]) begin
        n_fail++; $display("FAIL rstmid_new%0d: got v=%b %h want v=1 %h", i, out_valid, out_byte, nw[8*i +: 8]);
      end
      tick();
    end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_end: got v=%b want 0", out_valid); end
  endtask

`ifdef RC4SER_PARITY_EN
  task automatic test_parity();
    do_reset();
    out_ready  = 1'b1;
    ctxt_valid = 1'b1;
    ctxt_in    = 32'h000000FF;
    tick();
    ctxt_in    = 32'h00000001;
    tick();
    ctxt_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 0 || i == 4) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_parity !== ((i == 4) ? 1'b1 : 1'b0)) begin
          n_fail++; $display("FAIL parity_byte%0d: got v=%b p=%b b=%h", i, out_valid, out_parity, out_byte);
        end
      end
      tick();
    end
    n_checks++;
    if (out_parity !== 1'b0) begin n_fail++; $display("FAIL parity_idle: got %b want 0", out_parity); end
  endtask
`endif

  // Reference model: a flat queue of every byte still owed downstream, in order.
  task automatic test_random();
    logic [7:0]  q [$];
    logic [31:0] w;
    logic [7:0]  held;
    logic        held_v;
    logic        in_hs;
    logic        out_hs;
    logic        exp_valid;
    int          emitted;
    int          exp_cnt;
    int          prev_avail;
    do_reset();
    emitted   = 0;
    held_v    = 1'b0;
    held      = 8'h00;
    exp_valid = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      ctxt_valid = ($urandom_range(0, 99) < 40);
      w          = $urandom;
      ctxt_in    = w;
      out_ready  = ($urandom_range(0, 99) < 60);
      #1;
      if (exp_valid) exp_cnt = (q.size() - (4 - emitted % 4)) / 4;
      else           exp_cnt = q.size() / 4;
      n_checks++;
      if (out_valid !== exp_valid) begin
        n_fail++; $display("FAIL rand_valid c%0d: got %b want %b", cyc, out_valid, exp_valid);
      end
      n_checks++;
      if (fifo_count !== exp_cnt || ctxt_ready !== (exp_cnt != DEPTH)) begin
        n_fail++; $display("FAIL rand_count c%0d: got cnt=%0d rdy=%b want cnt=%0d", cyc, fifo_count, ctxt_ready, exp_cnt);
      end
      if (held_v) begin
        n_checks++;
        if (out_byte !== held) begin n_fail++; $display("FAIL rand_hold c%0d: got %h want %h", cyc, out_byte, held); end
      end
      if (out_valid && q.size() > 0) begin
        n_checks++;
        if (out_byte !== q[0]) begin n_fail++; $display("FAIL rand_byte c%0d: got %h want %h", cyc, out_byte, q[0]); end
      end
      in_hs  = ctxt_valid && (exp_cnt != DEPTH);
      out_hs = out_valid && out_ready;
      held_v = out_valid && !out_ready;
      held   = out_byte;
      tick();
      if (out_hs && q.size() > 0) begin
        void'(q.pop_front());
        emitted++;
      end
      // Bytes present before this edge keep the output busy; a word pushed
      // on this edge cannot appear until the next one.
      prev_avail = q.size();
      exp_valid  = (prev_avail > 0);
      if (in_hs) for (int b = 0; b < 4; b++) q.push_back(w[8*b +: 8]);
    end
    ctxt_valid = 1'b0;
    out_ready  = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    ctxt_valid = 1'b0;
    ctxt_in    = 32'h0;
    out_ready  = 1'b0;
    test_reset();
    test_single_word();
    test_full();
    test_back_to_back();
    test_toggle_ready();
    test_reset_mid_word();
`ifdef RC4SER_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
